// File: rtl/program_loader.sv
// Boot/run sequencer: streams a program into the core's instruction memory,
// holds the core in reset while loading, then runs it until halt, budget or abort.
module program_loader #(
  parameter int unsigned PC_SIZE    = 10,
  parameter int unsigned ADDR_STEP  = 4,
  parameter int unsigned RESET_HOLD = 4,
  parameter int unsigned RUN_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               halt,
  input  logic               word_valid,
  output logic               word_ready,
  input  logic [31:0]        word_data,
  input  logic               word_last,
  output logic               imem_load,
  output logic [PC_SIZE-1:0] PC_write,
  output logic [31:0]        instruction_in,
  output logic               core_reset,
  output logic [PC_SIZE-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned MaxWords = (2 ** PC_SIZE) / ADDR_STEP;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StRun,
    StDone,
    StError
  } state_e;

  state_e             r_state, w_state_d;
  logic [31:0]        r_cnt, w_cnt_d;
  logic [PC_SIZE-1:0] r_word_count, w_word_count_d;
  logic [PC_SIZE-1:0] r_pc, w_pc_d;
  logic [31:0]        r_instr, w_instr_d;
  logic               r_imem_load, w_imem_load_d;
  logic               r_core_reset, w_core_reset_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic               r_error, w_error_d;

  logic               w_accept;
  logic [PC_SIZE:0]   w_count_inc;
  logic               w_full;

  assign word_ready  = (r_state == StLoad) && !abort;
  assign w_accept    = word_valid && word_ready;
  // One extra bit so a full memory (MaxWords == 2^PC_SIZE) is still detectable.
  assign w_count_inc = {1'b0, r_word_count} + (PC_SIZE + 1)'(1);
  assign w_full      = (w_count_inc == (PC_SIZE + 1)'(MaxWords));

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_word_count_d = r_word_count;
    w_pc_d         = r_pc;
    w_instr_d      = r_instr;
    if (abort) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone, StError: begin
          if (start) begin
            w_state_d      = StLoad;
            w_word_count_d = '0;
          end
        end
        StLoad: begin
          if (w_accept) begin
            w_pc_d         = PC_SIZE'(32'(r_word_count) * ADDR_STEP);
            w_instr_d      = word_data;
            w_word_count_d = w_count_inc[PC_SIZE-1:0];
            if (word_last) begin
              w_state_d = StSettle;
              w_cnt_d   = '0;
            end else if (w_full) begin
              w_state_d = StError;
            end
          end
        end
        StSettle: begin
          if (r_cnt == 32'(RESET_HOLD - 1)) begin
            w_state_d = StRun;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 32'd1;
          end
        end
        StRun: begin
          if (halt || ((RUN_CYCLES != 0) && (r_cnt == 32'(RUN_CYCLES - 1)))) begin
            w_state_d = StDone;
          end else begin
            w_cnt_d = r_cnt + 32'd1;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // The final write (into SETTLE or ERROR) keeps imem_load high one more cycle.
  always_comb begin
    w_imem_load_d  = (w_state_d == StLoad) || ((r_state == StLoad) && w_accept);
    w_core_reset_d = (w_state_d != StRun);
    w_busy_d       = (w_state_d == StLoad) || (w_state_d == StSettle) || (w_state_d == StRun);
    w_done_d       = (w_state_d == StDone);
    w_error_d      = (w_state_d == StError);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_word_count <= '0;
      r_pc         <= '0;
      r_instr      <= '0;
      r_imem_load  <= 1'b0;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_word_count <= w_word_count_d;
      r_pc         <= w_pc_d;
      r_instr      <= w_instr_d;
      r_imem_load  <= w_imem_load_d;
      r_core_reset <= w_core_reset_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_error      <= w_error_d;
    end
  end

  assign imem_load      = r_imem_load;
  assign PC_write       = r_pc;
  assign instruction_in = r_instr;
  assign core_reset     = r_core_reset;
  assign word_count     = r_word_count;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;

endmodule
